// File: rtl/tmr_bus_pkg.sv
// tmr_bus_pkg: register map, FSM encoding and command layout
// shared by the timer bus master and its command FIFO.
package tmr_bus_pkg;

  localparam logic [1:0] ADDR_STARTSTOP = 2'b00;
  localparam logic [1:0] ADDR_TIMER1    = 2'b01;
  localparam logic [1:0] ADDR_TIMER2    = 2'b10;

  localparam int START_BIT  = 0;
  localparam int CNTCLR_BIT = 7;

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    STROBE,
    RECOVER
  } state_e;

  // Command word is {write, addr, wdata}, write in the MSB.
  function automatic int cmd_width(int aw, int dw);
    return 1 + aw + dw;
  endfunction

endpackage

// File: rtl/tmr_bus_master_if.sv
// tmr_bus_master_if: command, response and timer bus signals.
// master = bus master side, slave = sequencer + timer side.
interface tmr_bus_master_if #(
  parameter int ADDR_W = 2,
  parameter int DATA_W = 8
);
  logic              cmd_valid;
  logic              cmd_ready;
  logic              cmd_write;
  logic [ADDR_W-1:0] cmd_addr;
  logic [DATA_W-1:0] cmd_wdata;
  logic              rsp_valid;
  logic [ADDR_W-1:0] rsp_addr;
  logic [DATA_W-1:0] rsp_rdata;
  logic              busy;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic              write;
  logic              read;
  logic [DATA_W-1:0] rdata;

  modport master (
    input  cmd_valid, cmd_write, cmd_addr,
    input  cmd_wdata, rdata,
    output cmd_ready, rsp_valid, rsp_addr,
    output rsp_rdata, busy, addr, wdata,
    output write, read
  );

  modport slave (
    output cmd_valid, cmd_write, cmd_addr,
    output cmd_wdata, rdata,
    input  cmd_ready, rsp_valid, rsp_addr,
    input  rsp_rdata, busy, addr, wdata,
    input  write, read
  );
endinterface

// File: rtl/tmr_cmd_fifo.sv
// tmr_cmd_fifo: synchronous command FIFO, power-of-2 depth.
// Ports: push_i/pop_i/wdata_i in; rdata_o (head), full/empty/count out.
module tmr_cmd_fifo
  import tmr_bus_pkg::*;
#(
  parameter int WIDTH = cmd_width(2, 8),
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   push_i,
  input  logic                   pop_i,
  input  logic [WIDTH-1:0]       wdata_i,
  output logic [WIDTH-1:0]       rdata_o,
  output logic                   full_o,
  output logic                   empty_o,
  output logic [$clog2(DEPTH):0] count_o
);
  localparam int PW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_q;
  logic [PW-1:0]    rd_q;
  logic [PW:0]      cnt_q;
  logic             do_push;
  logic             do_pop;

  assign full_o  = cnt_q == (PW+1)'(DEPTH);
  assign empty_o = cnt_q == '0;
  assign count_o = cnt_q;
  assign rdata_o = mem_q[rd_q];
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      if (do_push) begin
        mem_q[wr_q] <= wdata_i;
        wr_q        <= wr_q + 1'b1;
      end
      if (do_pop) begin
        rd_q <= rd_q + 1'b1;
      end
      cnt_q <= cnt_q
             + {{PW{1'b0}}, do_push}
             - {{PW{1'b0}}, do_pop};
    end
  end
endmodule

// File: rtl/tmr_bus_master.sv
// tmr_bus_master: buffers commands and replays them on the timer bus.
// Ports: clk, rst_n, bus_if (cmd valid/ready, rsp pulse, timer bus).
module tmr_bus_master
  import tmr_bus_pkg::*;
#(
  parameter int ADDR_W     = 2,
  parameter int DATA_W     = 8,
  parameter int FIFO_DEPTH = 4,
  parameter int SETUP_CYC  = 1,
  parameter int STROBE_CYC = 1
) (
  input logic               clk,
  input logic               rst_n,
  tmr_bus_master_if.master  bus_if
);
  localparam int CMD_W = cmd_width(ADDR_W, DATA_W);
  localparam int MAXC  =
    SETUP_CYC > STROBE_CYC ? SETUP_CYC : STROBE_CYC;
  localparam int CW    = $clog2(MAXC + 1);
  localparam int NW    = $clog2(FIFO_DEPTH) + 1;

  localparam logic [CW-1:0] SETUP_LAST  = CW'(SETUP_CYC - 1);
  localparam logic [CW-1:0] STROBE_LAST = CW'(STROBE_CYC - 1);

  typedef struct packed {
    logic              write;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } cmd_t;

  state_e            state_q, state_d;
  logic [CW-1:0]     cyc_q, cyc_d;
  cmd_t              cmd_q;
  cmd_t              head;
  logic [DATA_W-1:0] rdata_q;
  logic              push;
  logic              pop;
  logic              full;
  logic              empty;
  logic [NW-1:0]     count;
  logic              on_bus;
  logic              strobe;
  logic              rsp;

  assign push = bus_if.cmd_valid && !full;

  tmr_cmd_fifo #(
    .WIDTH (CMD_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (push),
    .pop_i   (pop),
    .wdata_i ({bus_if.cmd_write,
               bus_if.cmd_addr,
               bus_if.cmd_wdata}),
    .rdata_o (head),
    .full_o  (full),
    .empty_o (empty),
    .count_o (count)
  );

  always_comb begin
    state_d = state_q;
    cyc_d   = cyc_q;
    pop     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (!empty) begin
          pop     = 1'b1;
          state_d = SETUP;
          cyc_d   = '0;
        end
      end
      SETUP: begin
        if (cyc_q == SETUP_LAST) begin
          state_d = STROBE;
          cyc_d   = '0;
        end else begin
          cyc_d = cyc_q + 1'b1;
        end
      end
      STROBE: begin
        if (cyc_q == STROBE_LAST) begin
          state_d = RECOVER;
          cyc_d   = '0;
        end else begin
          cyc_d = cyc_q + 1'b1;
        end
      end
      RECOVER: begin
        cyc_d = '0;
        if (!empty) begin
          pop     = 1'b1;
          state_d = SETUP;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cyc_q   <= '0;
      cmd_q   <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      cyc_q   <= cyc_d;
      if (pop) begin
        cmd_q <= head;
      end
      if (strobe && cyc_q == STROBE_LAST
          && !cmd_q.write) begin
        rdata_q <= bus_if.rdata;
      end
    end
  end

  // Bus outputs decode straight from registered state, so
  // an async reset clears them without waiting for a clock.
  assign on_bus = state_q == SETUP || state_q == STROBE;
  assign strobe = state_q == STROBE;
  assign rsp    = state_q == RECOVER && !cmd_q.write;

  assign bus_if.cmd_ready = count != NW'(FIFO_DEPTH);
  assign bus_if.busy      = !empty || state_q != IDLE;
  assign bus_if.addr      = on_bus ? cmd_q.addr : '0;
  assign bus_if.wdata     =
    (on_bus && cmd_q.write) ? cmd_q.wdata : '0;
  assign bus_if.write     = strobe && cmd_q.write;
  assign bus_if.read      = strobe && !cmd_q.write;
  assign bus_if.rsp_valid = rsp;
  assign bus_if.rsp_addr  = rsp ? cmd_q.addr : '0;
  assign bus_if.rsp_rdata = rsp ? rdata_q : '0;
endmodule

// File: tb/tb_tmr_bus_master.sv
// tb_tmr_bus_master: table vectors, hand sequences and random
// traffic against an ordered command/register reference model.
module tb_tmr_bus_master;

  logic clk = 1'b0;
  logic rst_n = 1'b1;

  always #5 clk = ~clk;

  tmr_bus_master_if #(.ADDR_W(2), .DATA_W(8)) mi ();
  tmr_bus_master_if #(.ADDR_W(2), .DATA_W(8)) mi2 ();

  tmr_bus_master #(
    .ADDR_W(2), .DATA_W(8), .FIFO_DEPTH(4),
    .SETUP_CYC(1), .STROBE_CYC(1)
  ) dut (
    .clk(clk), .rst_n(rst_n), .bus_if(mi)
  );

  tmr_bus_master #(
    .ADDR_W(2), .DATA_W(8), .FIFO_DEPTH(4),
    .SETUP_CYC(2), .STROBE_CYC(3)
  ) dut2 (
    .clk(clk), .rst_n(rst_n), .bus_if(mi2)
  );

  int nvec = 0;
  int nerr = 0;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h want %0h t=%0t",
               nm, act, exp, $time);
    end
  endtask

  // Timer register file: takes write strobes, serves reads.
  logic [7:0] tregs [4] = '{default: 8'h00};
  assign mi.rdata  = tregs[mi.addr];
  assign mi2.rdata = 8'h00;
  always @(posedge clk) begin
    if (rst_n && mi.write) tregs[mi.addr] <= mi.wdata;
  end

  // Reference model: commands execute in accept order, so a
  // read returns whatever the last earlier write stored.
  typedef struct packed {
    logic       w;
    logic [1:0] a;
    logic [7:0] d;
  } rec_t;

  logic [7:0] mm [4] = '{default: 8'h00};
  rec_t exp_cmd[$];
  rec_t exp_rsp[$];

  task automatic push(input logic w,
                      input logic [1:0] a,
                      input logic [7:0] d);
    int n;
    n = 0;
    mi.cmd_valid = 1'b1;
    mi.cmd_write = w;
    mi.cmd_addr  = a;
    mi.cmd_wdata = d;
    while (!mi.cmd_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) chk("push_timeout", 32'(n), 0);
    @(posedge clk);
    exp_cmd.push_back('{w, a, d});
    if (w) mm[a] = d;
    else exp_rsp.push_back('{1'b0, a, mm[a]});
    @(negedge clk);
    mi.cmd_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (mi.busy && n < 500) begin
      @(negedge clk);
      n++;
    end
    chk("drain_time", 32'(n >= 500), 0);
    @(negedge clk);
    chk("drain_cmdq", 32'(exp_cmd.size()), 0);
    chk("drain_rspq", 32'(exp_rsp.size()), 0);
  endtask

  // Bus monitor.
  int   cyc = 0;
  int   slen = 0;
  logic s, pstrobe = 1'b0;
  logic [1:0] paddr;
  logic [7:0] pwdata;
  rec_t e, r;
  int   starts[$];
  int   ready_low = 0;

  always @(negedge clk) begin
    cyc++;
    if (!rst_n) begin
      pstrobe = 1'b0;
      slen    = 0;
    end else begin
      s = mi.write | mi.read;
      if (!mi.cmd_ready) ready_low++;
      if (s && !pstrobe) begin
        starts.push_back(cyc);
        slen = 1;
        chk("strobe_excl", 32'(mi.write & mi.read), 0);
        if (exp_cmd.size() == 0) begin
          nvec++;
          nerr++;
          $display("FAIL strobe_unexpected: addr %0h",
                   mi.addr);
        end else begin
          e = exp_cmd.pop_front();
          chk("strobe_wr", 32'(mi.write), 32'(e.w));
          chk("strobe_addr", 32'(mi.addr), 32'(e.a));
          chk("strobe_wdata", 32'(mi.wdata),
              e.w ? 32'(e.d) : 0);
        end
      end else if (s) begin
        slen++;
        chk("strobe_hold",
            {22'd0, mi.addr, mi.wdata},
            {22'd0, paddr, pwdata});
      end else if (pstrobe) begin
        chk("strobe_len", 32'(slen), 1);
      end
      if (mi.rsp_valid) begin
        if (exp_rsp.size() == 0) begin
          nvec++;
          nerr++;
          $display("FAIL rsp_unexpected: addr %0h data %0h",
                   mi.rsp_addr, mi.rsp_rdata);
        end else begin
          r = exp_rsp.pop_front();
          chk("rsp_addr", 32'(mi.rsp_addr), 32'(r.a));
          chk("rsp_rdata", 32'(mi.rsp_rdata), 32'(r.d));
        end
      end
      pstrobe = s;
      paddr   = mi.addr;
      pwdata  = mi.wdata;
    end
  end

  // Single-command vectors issued from idle, checked per cycle.
  typedef struct {
    logic       w;
    logic [1:0] a;
    logic [7:0] d;
    logic [7:0] rsp;
  } vec_t;

  vec_t tbl[7];

  task automatic run_vec(input vec_t v);
    logic [7:0] wd;
    wd = v.w ? v.d : 8'h00;
    push(v.w, v.a, v.d);
    chk("c1_busy", 32'(mi.busy), 1);
    chk("c1_bus", {28'd0, mi.addr, mi.write, mi.read}, 0);
    @(negedge clk);
    chk("c2_addr", 32'(mi.addr), 32'(v.a));
    chk("c2_wdata", 32'(mi.wdata), 32'(wd));
    chk("c2_strb", {30'd0, mi.write, mi.read}, 0);
    @(negedge clk);
    chk("c3_addr", 32'(mi.addr), 32'(v.a));
    chk("c3_wdata", 32'(mi.wdata), 32'(wd));
    chk("c3_strb", {30'd0, mi.write, mi.read},
        {30'd0, v.w, !v.w});
    @(negedge clk);
    chk("c4_bus",
        {20'd0, mi.addr, mi.wdata, mi.write, mi.read}, 0);
    chk("c4_rspv", 32'(mi.rsp_valid), 32'(!v.w));
    if (!v.w) begin
      chk("c4_rsp_addr", 32'(mi.rsp_addr), 32'(v.a));
      chk("c4_rsp_data", 32'(mi.rsp_rdata), 32'(v.rsp));
    end
    @(negedge clk);
    chk("c5_busy", 32'(mi.busy), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [8:0] pat;
    logic       pw;
    int         rise[$];
    int         n;

    mi.cmd_valid  = 1'b0;
    mi.cmd_write  = 1'b0;
    mi.cmd_addr   = '0;
    mi.cmd_wdata  = '0;
    mi2.cmd_valid = 1'b0;
    mi2.cmd_write = 1'b0;
    mi2.cmd_addr  = '0;
    mi2.cmd_wdata = '0;

    tbl[0] = '{1'b1, 2'b00, 8'h80, 8'h00};
    tbl[1] = '{1'b1, 2'b00, 8'h01, 8'h00};
    tbl[2] = '{1'b1, 2'b01, 8'h49, 8'h00};
    tbl[3] = '{1'b1, 2'b10, 8'h09, 8'h00};
    tbl[4] = '{1'b0, 2'b00, 8'h00, 8'h01};
    tbl[5] = '{1'b0, 2'b01, 8'h00, 8'h49};
    tbl[6] = '{1'b0, 2'b10, 8'h00, 8'h09};

    #1 rst_n = 1'b0;
    #1;
    chk("rst_ready", 32'(mi.cmd_ready), 1);
    chk("rst_busy", 32'(mi.busy), 0);
    chk("rst_bus",
        {20'd0, mi.addr, mi.wdata, mi.write, mi.read}, 0);
    chk("rst_rsp",
        {21'd0, mi.rsp_valid, mi.rsp_addr, mi.rsp_rdata}, 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    foreach (tbl[i]) run_vec(tbl[i]);

    // Config writes back-to-back: one strobe every 3 cycles.
    starts.delete();
    ready_low = 0;
    push(1'b1, 2'b00, 8'h80);
    push(1'b1, 2'b00, 8'h01);
    push(1'b1, 2'b01, 8'h49);
    push(1'b1, 2'b10, 8'h09);
    drain();
    chk("cfg_nstrobe", 32'(starts.size()), 4);
    if (starts.size() == 4) begin
      for (int i = 0; i < 3; i++)
        chk("cfg_period", 32'(starts[i+1] - starts[i]), 3);
    end
    chk("cfg_ready_low", 32'(ready_low), 0);
    chk("cfg_reg0", 32'(tregs[0]), 32'h01);
    chk("cfg_reg1", 32'(tregs[1]), 32'h49);
    chk("cfg_reg2", 32'(tregs[2]), 32'h09);

    // Six commands: FIFO fills, ready drops, order kept.
    push(1'b1, 2'b11, 8'hAA);
    push(1'b0, 2'b11, 8'h00);
    push(1'b1, 2'b01, 8'h5A);
    push(1'b0, 2'b01, 8'h00);
    push(1'b1, 2'b10, 8'hC3);
    push(1'b0, 2'b10, 8'h00);
    chk("six_ready_full", 32'(mi.cmd_ready), 0);
    drain();
    chk("six_reg3", 32'(tregs[3]), 32'hAA);

    // Slow-timing instance: strobe cycles 4..6 after accept.
    @(negedge clk);
    chk("d2_ready", 32'(mi2.cmd_ready), 1);
    mi2.cmd_valid = 1'b1;
    mi2.cmd_write = 1'b1;
    mi2.cmd_addr  = 2'b01;
    mi2.cmd_wdata = 8'h55;
    @(posedge clk);
    @(negedge clk);
    mi2.cmd_valid = 1'b0;
    pat = '0;
    for (int k = 1; k <= 8; k++) begin
      pat[k] = mi2.write;
      if (k == 5)
        chk("d2_bus", {22'd0, mi2.addr, mi2.wdata},
            {22'd0, 2'b01, 8'h55});
      @(negedge clk);
    end
    chk("d2_pattern", 32'(pat), 32'h070);
    chk("d2_idle", 32'(mi2.busy), 0);
    mi2.cmd_valid = 1'b1;
    mi2.cmd_wdata = 8'h11;
    @(posedge clk);
    @(negedge clk);
    mi2.cmd_wdata = 8'h22;
    @(posedge clk);
    @(negedge clk);
    mi2.cmd_valid = 1'b0;
    pw = 1'b0;
    for (int k = 0; k < 24; k++) begin
      if (mi2.write && !pw) rise.push_back(k);
      pw = mi2.write;
      @(negedge clk);
    end
    chk("d2_nrise", 32'(rise.size()), 2);
    if (rise.size() == 2)
      chk("d2_period", 32'(rise[1] - rise[0]), 6);

    // Reset in the middle of a read strobe.
    push(1'b0, 2'b01, 8'h00);
    n = 0;
    while (!mi.read && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("mid_read_seen", 32'(mi.read), 1);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_read", 32'(mi.read), 0);
    chk("mid_rst_addr", 32'(mi.addr), 0);
    chk("mid_rst_rspv", 32'(mi.rsp_valid), 0);
    chk("mid_rst_busy", 32'(mi.busy), 0);
    chk("mid_rst_ready", 32'(mi.cmd_ready), 1);
    exp_cmd.delete();
    exp_rsp.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("mid_no_rsp", 32'(mi.rsp_valid), 0);
    end
    run_vec(tbl[0]);

    // Random traffic against the reference model.
    for (int i = 0; i < 40; i++) begin
      repeat ($urandom_range(0, 3)) @(negedge clk);
      push(1'($urandom_range(0, 1)),
           2'($urandom_range(0, 3)),
           8'($urandom));
    end
    drain();

    $display("== %0d vectors applied, %0d miscompares ==",
             nvec, nerr);
    $finish;
  end

endmodule
